ft245_fifo_port: RTL and testbench

FT245_FIFO_PORT -- requirements
Module: ft245_fifo_port

---
 rtl/ft245_fifo_port.sv | 111 +++++++++++
 tb/tb_ft245_fifo_port.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ft245_fifo_port.sv
// ft245_fifo_port: FT245-style async bus port with RX/TX byte FIFOs to a valid/ready link.
// Bus strobes are synchronized and edge-detected; edges are ignored until the synchronizer holds real samples.
module ft245_fifo_port #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       _rd,
    input  logic       wr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       _rdf,
    output logic       _txe,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       err_underrun,
    output logic       err_overrun,
    input  logic       err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [AW:0] cnt_rx, cnt_tx, cnt_rx_n, cnt_tx_n;
    logic [2:0] rd_s, wr_s;
    logic [7:0] din_s1, din_s2, din_s3;
    logic [1:0] st;
    logic ready, wr_arm, rd_emp;
    logic rd_fall, rd_rise, wr_fall, wr_rise;
    logic rx_push, rx_pop, tx_push, tx_pop, unr, ovr;

    // stage [1] is the second synchronizer flop, stage [2] its history for edge detection
    assign ready   = st == 2'd3;
    assign rd_fall = ready & rd_s[2] & ~rd_s[1];
    assign rd_rise = ready & ~rd_s[2] & rd_s[1];
    assign wr_rise = ready & ~wr_s[2] & wr_s[1];
    assign wr_fall = ready & wr_s[2] & ~wr_s[1];
    assign unr     = rd_fall & (cnt_rx == '0);
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = rd_rise & d_oe & ~rd_emp;
    assign tx_push = wr_fall & wr_arm & (cnt_tx != FULL);
    assign ovr     = wr_fall & wr_arm & (cnt_tx == FULL);
    assign tx_pop  = tx_valid & tx_ready;
    assign cnt_rx_n = cnt_rx + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    assign cnt_tx_n = cnt_tx + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    assign tx_data = tx_mem[tx_rp];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
        if (tx_push) tx_mem[tx_wp] <= din_s3;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rd_s <= 3'b111;
            wr_s <= 3'b000;
            din_s1 <= 8'h00;
            din_s2 <= 8'h00;
            din_s3 <= 8'h00;
            st <= 2'd0;
            wr_arm <= 1'b0;
            rd_emp <= 1'b0;
            d_oe <= 1'b0;
            d_out <= 8'h00;
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
            cnt_rx <= '0;
            cnt_tx <= '0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            _rdf <= 1'b1;
            _txe <= 1'b0;
            err_underrun <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            rd_s <= {rd_s[1:0], _rd};
            wr_s <= {wr_s[1:0], wr};
            din_s1 <= d_in;
            din_s2 <= din_s1;
            din_s3 <= din_s2;
            st <= ready ? st : st + 2'd1;
            wr_arm <= wr_rise | (wr_arm & ~wr_fall);
            if (rd_fall) begin
                d_oe <= 1'b1;
                rd_emp <= unr;
                d_out <= unr ? 8'h00 : rx_mem[rx_rp];
            end else if (rd_rise) d_oe <= 1'b0;
            rx_wp <= rx_wp + AW'(rx_push);
            rx_rp <= rx_rp + AW'(rx_pop);
            tx_wp <= tx_wp + AW'(tx_push);
            tx_rp <= tx_rp + AW'(tx_pop);
            cnt_rx <= cnt_rx_n;
            cnt_tx <= cnt_tx_n;
            rx_ready <= cnt_rx_n != FULL;
            tx_valid <= cnt_tx_n != '0;
            _rdf <= cnt_rx == '0;
            _txe <= cnt_tx == FULL;
            err_underrun <= unr | (err_underrun & ~err_clr);
            err_overrun <= ovr | (err_overrun & ~err_clr);
        end
    end
endmodule

// File: tb/tb_ft245_fifo_port.sv
// tb_ft245_fifo_port: directed vectors for the FT245 FIFO port with hand-computed expectations.
module tb_ft245_fifo_port;
    logic clk = 1'b0, rst_n = 1'b0, rd_n = 1'b1, wr = 1'b0;
    logic [7:0] d_in = 8'h00, d_out, rx_data = 8'h00, tx_data;
    logic d_oe, rdf_n, txe_n, rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b0;
    logic err_underrun, err_overrun, err_clr = 1'b0;
    int n_vec = 0, n_err = 0;
    logic [7:0] b;

    ft245_fifo_port #(.DEPTH(16)) dut (
        .clk(clk), ._reset(rst_n), ._rd(rd_n), .wr(wr), .d_in(d_in),
        .d_out(d_out), .d_oe(d_oe), ._rdf(rdf_n), ._txe(txe_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_underrun(err_underrun), .err_overrun(err_overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_byte(output logic [7:0] v);
        rd_n = 1'b0;
        tick(3);
        chk("rd_oe", d_oe, 1);
        v = d_out;
        tick(1);
        rd_n = 1'b1;
        tick(4);
        chk("rd_oe_drop", d_oe, 0);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        d_in = v;
        wr = 1'b1;
        tick(3);
        wr = 1'b0;
        tick(4);
    endtask

    task automatic link_push(input logic [7:0] v);
        rx_data = v;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_d_oe", d_oe, 0);
        chk("rst_d_out", d_out, 8'h00);
        chk("rst_rdf", rdf_n, 1);
        chk("rst_txe", txe_n, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_errs", {err_underrun, err_overrun}, 0);
        rst_n = 1'b1;
        tick(1);
        chk("rx_ready_rise", rx_ready, 1);
        tick(4);

        rx_data = 8'hA5;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        chk("rdf_lag", rdf_n, 1);
        tick(1);
        chk("rdf_low", rdf_n, 0);
        rd_n = 1'b0;
        tick(2);
        chk("rd_oe_early", d_oe, 0);
        tick(1);
        chk("rd_oe_3rd", d_oe, 1);
        chk("rd_a5", d_out, 8'hA5);
        tick(1);
        rd_n = 1'b1;
        tick(4);
        chk("rd_release_oe", d_oe, 0);
        chk("rd_release_rdf", rdf_n, 1);

        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        chk("tx_valid", tx_valid, 1);
        chk("tx_head", tx_data, 8'h11);
        tx_ready = 1'b1;
        chk("tx_0", tx_data, 8'h11);
        tick(1);
        chk("tx_1", tx_data, 8'h22);
        tick(1);
        chk("tx_2", tx_data, 8'h33);
        tick(1);
        tx_ready = 1'b0;
        chk("tx_drained", tx_valid, 0);

        for (int i = 1; i <= 17; i++) begin
            wr_byte(8'(i));
            if (i == 15) chk("txe_15", txe_n, 0);
            if (i == 16) chk("txe_16", txe_n, 1);
            if (i == 16) chk("ovr_16", err_overrun, 0);
        end
        chk("ovr_17", err_overrun, 1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain", {tx_valid, tx_data}, {1'b1, 8'(i)});
            tick(1);
        end
        tx_ready = 1'b0;
        chk("drain_empty", tx_valid, 0);
        tick(1);
        chk("txe_after_drain", txe_n, 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovr_clr", err_overrun, 0);

        rd_n = 1'b0;
        tick(3);
        chk("unr_oe", d_oe, 1);
        chk("unr_dout", d_out, 8'h00);
        chk("unr_flag", err_underrun, 1);
        tick(1);
        rd_n = 1'b1;
        tick(4);
        chk("unr_rdf", rdf_n, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("unr_clr", err_underrun, 0);

        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h40 + 8'(i);
            tick(1);
        end
        chk("rx_full_ready", rx_ready, 0);
        rx_data = 8'h50;
        rd_n = 1'b0;
        tick(3);
        chk("full_head", d_out, 8'h40);
        tick(1);
        rd_n = 1'b1;
        tick(3);
        chk("full_pop_ready", rx_ready, 1);
        tick(1);
        chk("full_refill", rx_ready, 0);
        rx_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            rd_byte(b);
            chk("rx_order", b, 8'h40 + 8'(i));
        end
        chk("rx_empty", rdf_n, 1);
        chk("rx_no_unr", err_underrun, 0);

        link_push(8'h77);
        tick(1);
        rd_n = 1'b0;
        tick(3);
        chk("mid_oe", d_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe", d_oe, 0);
        chk("async_rdf", rdf_n, 1);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        rd_n = 1'b1;
        tick(6);
        chk("post_rst_oe", d_oe, 0);
        chk("post_rst_unr", err_underrun, 0);
        chk("post_rst_rdf", rdf_n, 1);
        link_push(8'h99);
        tick(1);
        rd_byte(b);
        chk("post_rst_data", b, 8'h99);
        chk("post_rst_empty", rdf_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
